// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-stage access sequencer.
// Contents: the datapath width, the FSM state encoding, the load funct3 codes,
// the MWControl store-mask codes, and the latched request record.
package mem_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } mau_state_e;

  // Load width/sign selectors (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Unshifted store masks as produced by MWControl
  localparam logic [3:0] WM_NONE = 4'b0000;
  localparam logic [3:0] WM_SB   = 4'b0001;
  localparam logic [3:0] WM_SH   = 4'b0011;
  localparam logic [3:0] WM_SW   = 4'b1111;

  // Instruction fields captured when a memory op enters the sequencer
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [3:0]      wmask;
    logic            re;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic            rwe;
  } mem_req_t;
endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side and data-cache-side signals of the memory stage.
// slave  : the sequencer (consumes pipeline controls and cache responses,
//          drives stall, cache request and writeback result).
// master : the surrounding pipeline plus data cache.
interface mem_access_unit_if import mem_pkg::*; ();
  // pipeline -> sequencer
  logic            mem_valid;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] store_data;
  logic [3:0]      w_mask;
  logic            re;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic            rwe;
  logic            stall;
  // data cache
  logic            dcache_req_valid;
  logic            dcache_req_ready;
  logic [XLEN-3:0] dcache_addr;
  logic [3:0]      dcache_we;
  logic [XLEN-1:0] dcache_din;
  logic            dcache_resp_valid;
  logic [XLEN-1:0] dcache_dout;
  // writeback
  logic            mem_done;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_load_data;

  modport slave (
    input  mem_valid, addr, store_data, w_mask, re, funct3, rd, rwe,
           dcache_req_ready, dcache_resp_valid, dcache_dout,
    output stall, dcache_req_valid, dcache_addr, dcache_we, dcache_din,
           mem_done, wb_we, wb_rd, wb_load_data
  );

  modport master (
    output mem_valid, addr, store_data, w_mask, re, funct3, rd, rwe,
           dcache_req_ready, dcache_resp_valid, dcache_dout,
    input  stall, dcache_req_valid, dcache_addr, dcache_we, dcache_din,
           mem_done, wb_we, wb_rd, wb_load_data
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// load_align: combinational load-data extractor, shared with writeback.
// Ports: dout_i (raw cache word), off_i (byte offset), funct3_i (width/sign)
//        -> data_o (aligned, sign/zero-extended result; 0 for unknown funct3).
module load_align import mem_pkg::*; #(
  parameter int W = XLEN
) (
  input  logic [W-1:0] dout_i,
  input  logic [1:0]   off_i,
  input  logic [2:0]   funct3_i,
  output logic [W-1:0] data_o
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'(dout_i >> {off_i, 3'b000});
    // halfword lane is picked by off[1] only; off[0] is ignored for LH/LHU
    h = 16'(dout_i >> {off_i[1], 4'b0000});
    unique case (funct3_i)
      F3_LB:   data_o = {{(W-8){b[7]}}, b};
      F3_LBU:  data_o = {{(W-8){1'b0}}, b};
      F3_LH:   data_o = {{(W-16){h[15]}}, h};
      F3_LHU:  data_o = {{(W-16){1'b0}}, h};
      F3_LW:   data_o = dout_i;
      default: data_o = '0;
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage access sequencer.
// Ports: clk, rst_n (async, active-low), mau (slave modport: pipeline
// controls in, stall out, dcache valid/ready request, load response,
// one-cycle mem_done with writeback rd/we/data).
// One access in flight at most: IDLE -> REQ -> (WAIT for loads) -> DONE.
module mem_access_unit import mem_pkg::*; (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave mau
);
  mau_state_e      state_q, state_d;
  mem_req_t        req_q, req_d;
  logic [XLEN-1:0] ld_q, ld_d;
  logic [XLEN-1:0] align_data;
  logic            mem_op;
  logic [1:0]      off;

  assign mem_op = mau.mem_valid & (mau.re | (mau.w_mask != WM_NONE));
  assign off    = req_q.addr[1:0];

  load_align #(.W(XLEN)) u_align (
    .dout_i   (mau.dcache_dout),
    .off_i    (off),
    .funct3_i (req_q.funct3),
    .data_o   (align_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      ld_q    <= ld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    ld_d    = ld_q;
    unique case (state_q)
      S_IDLE: if (mem_op) begin
        req_d = '{addr: mau.addr, data: mau.store_data, wmask: mau.w_mask,
                  re: mau.re, funct3: mau.funct3, rd: mau.rd, rwe: mau.rwe};
        state_d = S_REQ;
      end
      S_REQ:  if (mau.dcache_req_ready) state_d = req_q.re ? S_WAIT : S_DONE;
      S_WAIT: if (mau.dcache_resp_valid) begin
        ld_d    = align_data;
        state_d = S_DONE;
      end
      // inputs still show the finished instruction here; do not re-launch it
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // stall is combinational in IDLE so the op is frozen the cycle it arrives
  assign mau.stall = ((state_q == S_IDLE) & mem_op) | (state_q == S_REQ) |
                     (state_q == S_WAIT);

  // request fields come from latched state only, so they stay stable under backpressure
  assign mau.dcache_req_valid = (state_q == S_REQ);
  assign mau.dcache_addr      = req_q.addr[XLEN-1:2];
  // mask is truncated to 4 bits: misaligned SH at off=3 writes byte 3 only
  assign mau.dcache_we        = req_q.re ? 4'b0000 : (req_q.wmask << off);
  assign mau.dcache_din       = req_q.data << {off, 3'b000};

  assign mau.mem_done     = (state_q == S_DONE);
  assign mau.wb_we        = (state_q == S_DONE) & req_q.rwe & req_q.re;
  assign mau.wb_rd        = req_q.rd;
  assign mau.wb_load_data = ld_q;
endmodule
